bf16_div: RTL and testbench
===========================

BF16_DIV -- requirements
Module: bf16_div

Interface
REQ-001 Parameter: E, default 8, exponent width.
REQ-002 Parameter: M, default 7, stored mantissa width (hidden 1 not stored).
REQ-003 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: nreset  in  1  asynchronous, active-low reset.
REQ-005 Port: valid_i  in  1  operand pair valid.
REQ-006 Port: ready_o  out  1  block accepts operands.
REQ-007 Ports: sa_i / ea_i / ma_i  in  1 / E / M  dividend sign, exponent, mantissa.
REQ-008 Ports: sb_i / eb_i / mb_i  in  1 / E / M  divisor sign, exponent, mantissa.
REQ-009 Port: valid_o  out  1  result valid.
REQ-010 Port: ready_i  in  1  downstream accepts result.
REQ-011 Ports: s_o / e_o / m_o  out  1 / E / M  quotient c = a/b.
REQ-012 Port: dz_o  out  1  divide-by-zero flag, qualified by valid_o.

Function
REQ-013 FSM states: IDLE, DIV, NORM, DONE; ready_o is high only in IDLE.
REQ-014 IDLE->DIV on valid_i & ready_o; operands are captured on that edge, and later input changes have no effect.
REQ-015 Sign: s = sa ^ sb; exponent held in a signed (E+2)-bit intermediate, ea - eb + 127.
REQ-016 DIV: restoring division; remainder init {1,ma}, divisor {1,mb}; exactly 9 iterations, one quotient bit per cycle, MSB first (r>=d: bit=1, r-=d; then r<<=1).
REQ-017 NORM: if q[8]=1, m=q[7:1] and exponent unchanged; else m=q[6:0] and exponent-1; remainder discarded (round toward zero).
REQ-018 NORM: biased exponent >= 255 saturates to 0x7F7F magnitude (max finite, RTZ); exponent <= 0 flushes to signed zero.
REQ-019 valid_o rises 11 cycles after the accepting edge; state is DONE while valid_o=1.
REQ-020 DONE: s_o/e_o/m_o/dz_o stay stable while ready_i=0; on valid_o & ready_i, go to IDLE; no new accept in that cycle.
REQ-021 Inputs with e=0 are treated as zero (subnormals flushed); results are never subnormal.
REQ-022 valid_i is ignored outside IDLE; there is no input buffering.

Reset
REQ-023 nreset low asynchronously forces IDLE; valid_o=0, ready_o=1 after release, s_o/e_o/m_o/dz_o=0.
REQ-024 Reset mid-DIV/NORM/DONE aborts the operation; no partial result is ever presented.

Configuration
REQ-025 Macro BF16_DIV_SPECIAL_EN, when defined, enables special-operand handling, decided at capture.
REQ-026 With the macro, special results bypass DIV/NORM and go to DONE; valid_o rises 2 cycles after the accepting edge.
REQ-027 With the macro, divisor zero and dividend nonzero-finite gives signed inf (e=0xFF, m=0) and dz_o=1.
REQ-028 With the macro, dividend zero and divisor nonzero gives signed zero.
REQ-029 With the macro, any exponent 0xFF input or 0/0 gives NaN 0x7FC0 with dz_o=0 (0/0: dz_o=0).
REQ-030 Without the macro, all inputs take the normal DIV path (zero treated as 1.m x 2^-127 per REQ-021 flush), and dz_o is tied 0.

Structure
REQ-031 Shared package bf16_pkg holds E, M, BIAS=127, the FSM state enum, and constants QNAN=0x7FC0, MAXF=0x7F7F, INF_EXP=0xFF.
REQ-032 No sub-module; the 9-iteration datapath is a single iterative subtract/shift stage inside bf16_div.

Verification
REQ-033 0x3F80 / 0x3F80 (1.0/1.0) -> 0x3F80, valid_o at accept+11, dz_o=0.
REQ-034 0x4040 / 0x4000 (3.0/2.0) -> 0x3FC0; 0x3F80 / 0x4040 (1/3) -> 0x3EAA (truncated).
REQ-035 0xC0C0 / 0x4000 (-6/2) -> 0xC040; 0x7F00 / 0x0080 -> 0x7F7F (overflow saturates).
REQ-036 ready_i held 0 for 5 cycles in DONE -> outputs stable and ready_o=0; second valid_i during DIV is ignored.
REQ-037 nreset pulsed low at DIV iteration 4 -> IDLE, valid_o=0; the next operation 0x4000/0x3F80 -> 0x4000 correctly.
REQ-038 Macro defined: 0x3F80 / 0x0000 -> 0x7F80 with dz_o=1 at accept+2; 0x7F80 / 0x3F80 -> 0x7FC0 with dz_o=0.

Source files
------------

// File: rtl/bf16_pkg.sv
// -----------------------------------------------------------------------------
// bf16_pkg
// Shared definitions for the bfloat16 divider: default field widths, exponent
// bias, encodings of the special results, and the divider FSM state type.
// No ports.
// -----------------------------------------------------------------------------
package bf16_pkg;

    localparam int unsigned E    = 8;    // exponent width
    localparam int unsigned M    = 7;    // stored mantissa width
    localparam int unsigned BIAS = 127;  // exponent bias

    localparam logic [15:0] QNAN    = 16'h7FC0;  // canonical quiet NaN
    localparam logic [15:0] MAXF    = 16'h7F7F;  // largest finite magnitude
    localparam logic [7:0]  INF_EXP = 8'hFF;     // all-ones exponent

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/bf16_div.sv
// -----------------------------------------------------------------------------
// bf16_div
// Iterative bfloat16 divider c = a / b, round toward zero, subnormals flushed.
// One operand pair is accepted in IDLE; a restoring divider produces one
// quotient bit per cycle, then a normalise step forms the result, which is held
// in DONE until the downstream handshake completes.
//
// Optional feature: define BF16_DIV_SPECIAL_EN to resolve zero / inf / NaN
// operands at capture (fast path straight to DONE, divide-by-zero flag).
//
// Ports
//   clk, nreset            clock, asynchronous active-low reset
//   valid_i / ready_o      operand handshake (ready_o high only in IDLE)
//   sa_i, ea_i, ma_i       dividend sign / exponent / mantissa
//   sb_i, eb_i, mb_i       divisor sign / exponent / mantissa
//   valid_o / ready_i      result handshake
//   s_o, e_o, m_o          quotient sign / exponent / mantissa
//   dz_o                   divide-by-zero flag, qualified by valid_o
// -----------------------------------------------------------------------------
module bf16_div
    import bf16_pkg::*;
#(
    parameter int unsigned E = 8,
    parameter int unsigned M = 7
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         sa_i,
    input  logic [E-1:0] ea_i,
    input  logic [M-1:0] ma_i,
    input  logic         sb_i,
    input  logic [E-1:0] eb_i,
    input  logic [M-1:0] mb_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         s_o,
    output logic [E-1:0] e_o,
    output logic [M-1:0] m_o,
    output logic         dz_o
);

    localparam int unsigned EW     = E + 2;            // signed exponent intermediate
    localparam int unsigned QW     = M + 2;            // quotient bits = iterations
    localparam int unsigned CW     = $clog2(QW);
    localparam int unsigned EMAX   = (1 << E) - 1;     // all-ones exponent
    localparam int unsigned BIAS_L = (1 << (E - 1)) - 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [M+1:0]          rem_q, rem_d;
    logic [M:0]            dvs_q, dvs_d;
    logic [M+1:0]          quo_q, quo_d;
    logic signed [EW-1:0]  exp_q, exp_d;
    logic                  sgn_q, sgn_d;
    logic                  spec_q, spec_d;
    logic                  res_s_q, res_s_d;
    logic [E-1:0]          res_e_q, res_e_d;
    logic [M-1:0]          res_m_q, res_m_d;
    logic                  res_dz_q, res_dz_d;
    logic                  s_q, s_d;
    logic [E-1:0]          e_q, e_d;
    logic [M-1:0]          m_q, m_d;
    logic                  dz_q, dz_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;

    logic                  accept_c;
    logic                  a_zero_c, b_zero_c;
    logic [M-1:0]          ma_eff_c, mb_eff_c;
    logic signed [EW-1:0]  exp_cap_c;
    logic                  spec_c, sp_s_c, sp_dz_c;
    logic [E-1:0]          sp_e_c;
    logic [M-1:0]          sp_m_c;
    logic                  rem_ge_c;
    logic [M+1:0]          rem_sub_c;
    logic signed [EW-1:0]  norm_e_c;
    logic [M-1:0]          norm_m_c;
    logic [E-1:0]          fin_e_c;
    logic [M-1:0]          fin_m_c;

    assign accept_c = valid_i && ready_q;

    // Operand decode at capture: e=0 operands are flushed to 1.0 x 2^-bias
    always_comb begin
        a_zero_c  = (ea_i == '0);
        b_zero_c  = (eb_i == '0);
        ma_eff_c  = a_zero_c ? '0 : ma_i;
        mb_eff_c  = b_zero_c ? '0 : mb_i;
        exp_cap_c = EW'(ea_i) - EW'(eb_i) + EW'(BIAS_L);
    end

    // Special-operand classification; without the feature nothing is special
    always_comb begin
        spec_c  = 1'b0;
        sp_s_c  = 1'b0;
        sp_e_c  = '0;
        sp_m_c  = '0;
        sp_dz_c = 1'b0;
`ifdef BF16_DIV_SPECIAL_EN
        if ((ea_i == E'(EMAX)) || (eb_i == E'(EMAX)) || (a_zero_c && b_zero_c)) begin
            // NaN/inf operand or 0/0: canonical positive quiet NaN
            spec_c = 1'b1;
            sp_e_c = E'(EMAX);
            sp_m_c = {1'b1, {(M-1){1'b0}}};
        end else if (b_zero_c) begin
            spec_c  = 1'b1;
            sp_s_c  = sa_i ^ sb_i;
            sp_e_c  = E'(EMAX);
            sp_dz_c = 1'b1;
        end else if (a_zero_c) begin
            spec_c = 1'b1;
            sp_s_c = sa_i ^ sb_i;
        end
`endif
    end

    // One restoring-division step: subtract when possible, then shift left
    always_comb begin
        rem_ge_c  = (rem_q >= {1'b0, dvs_q});
        rem_sub_c = rem_ge_c ? (rem_q - {1'b0, dvs_q}) : rem_q;
    end

    // Normalise: quotient lies in (0.5, 2), so at most one left shift is needed
    always_comb begin
        if (quo_q[M+1]) begin
            norm_m_c = quo_q[M:1];
            norm_e_c = exp_q;
        end else begin
            norm_m_c = quo_q[M-1:0];
            norm_e_c = exp_q - EW'(1);
        end
        if (int'(norm_e_c) >= int'(EMAX)) begin
            fin_e_c = E'(EMAX - 1);
            fin_m_c = '1;
        end else if (int'(norm_e_c) <= 0) begin
            fin_e_c = '0;
            fin_m_c = '0;
        end else begin
            fin_e_c = norm_e_c[E-1:0];
            fin_m_c = norm_m_c;
        end
    end

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_c) state_d = DIV;
            DIV: begin
                if (spec_q)                        state_d = DONE;
                else if (cnt_q == CW'(QW - 1))     state_d = NORM;
            end
            NORM: state_d = DONE;
            DONE: if (valid_q && ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        sgn_d    = sgn_q;
        spec_d   = spec_q;
        res_s_d  = res_s_q;
        res_e_d  = res_e_q;
        res_m_d  = res_m_q;
        res_dz_d = res_dz_q;
        s_d      = s_q;
        e_d      = e_q;
        m_d      = m_q;
        dz_d     = dz_q;
        valid_d  = valid_q;
        ready_d  = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    sgn_d    = sa_i ^ sb_i;
                    exp_d    = exp_cap_c;
                    rem_d    = {1'b0, 1'b1, ma_eff_c};
                    dvs_d    = {1'b1, mb_eff_c};
                    quo_d    = '0;
                    cnt_d    = '0;
                    spec_d   = spec_c;
                    res_s_d  = sp_s_c;
                    res_e_d  = sp_e_c;
                    res_m_d  = sp_m_c;
                    res_dz_d = sp_dz_c;
                end
            end
            DIV: begin
                if (!spec_q) begin
                    rem_d = {rem_sub_c[M:0], 1'b0};
                    quo_d = {quo_q[M:0], rem_ge_c};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NORM: begin
                res_s_d  = sgn_q;
                res_e_d  = fin_e_c;
                res_m_d  = fin_m_c;
                res_dz_d = 1'b0;
            end
            DONE: begin
                // First DONE cycle publishes the result; it then holds until taken
                if (!valid_q) begin
                    s_d     = res_s_q;
                    e_d     = res_e_q;
                    m_d     = res_m_q;
                    dz_d    = res_dz_q;
                    valid_d = 1'b1;
                end else if (ready_i) begin
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            exp_q    <= '0;
            sgn_q    <= 1'b0;
            spec_q   <= 1'b0;
            res_s_q  <= 1'b0;
            res_e_q  <= '0;
            res_m_q  <= '0;
            res_dz_q <= 1'b0;
            s_q      <= 1'b0;
            e_q      <= '0;
            m_q      <= '0;
            dz_q     <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            sgn_q    <= sgn_d;
            spec_q   <= spec_d;
            res_s_q  <= res_s_d;
            res_e_q  <= res_e_d;
            res_m_q  <= res_m_d;
            res_dz_q <= res_dz_d;
            s_q      <= s_d;
            e_q      <= e_d;
            m_q      <= m_d;
            dz_q     <= dz_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign s_o     = s_q;
    assign e_o     = e_q;
    assign m_o     = m_q;
    assign dz_o    = dz_q;

endmodule

// File: tb/tb_bf16_div.sv
// -----------------------------------------------------------------------------
// tb_bf16_div
// Self-checking bench for bf16_div: arithmetic reference model of the quotient,
// a scoreboard queue compared on every cycle valid_o is high, directed corner
// cases and randomized operand pairs. Honours BF16_DIV_SPECIAL_EN.
// -----------------------------------------------------------------------------
module tb_bf16_div;
    import bf16_pkg::*;

    localparam int P = 10;

    logic       clk     = 1'b0;
    logic       nreset  = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b1;
    logic       sa_i    = 1'b0;
    logic [7:0] ea_i    = 8'h00;
    logic [6:0] ma_i    = 7'h00;
    logic       sb_i    = 1'b0;
    logic [7:0] eb_i    = 8'h00;
    logic [6:0] mb_i    = 7'h00;
    logic       ready_o, valid_o, s_o, dz_o;
    logic [7:0] e_o;
    logic [6:0] m_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    logic        prev_valid = 1'b0;
    logic [16:0] exp_q[$];       // {dz, s, e, m}
    int          lat_q[$];
    longint      acc_q[$];

    always #(P/2) clk = ~clk;

    bf16_div #(.E(8), .M(7)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sa_i    (sa_i),
        .ea_i    (ea_i),
        .ma_i    (ma_i),
        .sb_i    (sb_i),
        .eb_i    (eb_i),
        .mb_i    (mb_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .s_o     (s_o),
        .e_o     (e_o),
        .m_o     (m_o),
        .dz_o    (dz_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference quotient from plain integer arithmetic.
    // Returns {special_path, dz, sign, exp[7:0], mant[6:0]}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
        int   ea, eb, av, bv, q, ex, mm;
        logic s;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);
        eb = int'(b[14:7]);
`ifdef BF16_DIV_SPECIAL_EN
        if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) return {1'b1, 1'b0, QNAN};
        if (eb == 0) return {1'b1, 1'b1, s, INF_EXP, 7'h00};
        if (ea == 0) return {1'b1, 1'b0, s, 15'h0000};
`endif
        av = (ea == 0) ? 128 : 128 + int'(a[6:0]);
        bv = (eb == 0) ? 128 : 128 + int'(b[6:0]);
        q  = (av * 256) / bv;
        ex = ea - eb + 127;
        if (q >= 256) begin
            mm = (q / 2) % 128;
        end else begin
            mm = q % 128;
            ex = ex - 1;
        end
        if (ex >= 255) return {2'b00, s, MAXF[14:0]};
        if (ex <= 0)   return {2'b00, s, 15'h0000};
        return {2'b00, s, 8'(ex), 7'(mm)};
    endfunction

    // Downstream ready pattern
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = 1'($urandom_range(0, 1));
            default: ready_i = 1'b0;
        endcase
    end

    // Scoreboard compare on every cycle the result is presented
    always @(negedge clk) begin
        if (!nreset) begin
            prev_valid = 1'b0;
        end else begin
            if (valid_o) begin
                check("ready_o while valid_o", 32'(ready_o), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious result: got %0h, expected no valid_o at %0t",
                             {dz_o, s_o, e_o, m_o}, $time);
                end else begin
                    if (!prev_valid)
                        check("latency", 32'($time - acc_q[0]), 32'(lat_q[0] * P + P / 2));
                    check("result {dz,s,e,m}", 32'({dz_o, s_o, e_o, m_o}), 32'(exp_q[0]));
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_valid = valid_o;
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [17:0] expv);
        int t = 0;
        @(negedge clk);
        while (!ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ready_o before issue", 32'(ready_o), 32'd1);
        if (!ready_o) return;
        sa_i = a[15]; ea_i = a[14:7]; ma_i = a[6:0];
        sb_i = b[15]; eb_i = b[14:7]; mb_i = b[6:0];
        valid_i = 1'b1;
        @(posedge clk);
        exp_q.push_back(expv[16:0]);
        lat_q.push_back(expv[17] ? 2 : 11);
        acc_q.push_back(longint'($time));
        #1;
        valid_i = 1'b0;
        // Operands change after capture and must not affect the result
        {sa_i, ea_i, ma_i} = 16'($urandom);
        {sb_i, eb_i, mb_i} = 16'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || valid_o) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("results outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [15:0] rand_op();
        logic [7:0] e;
        case ($urandom_range(0, 7))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'(1 + $urandom_range(0, 2));
            3:       e = 8'(252 + $urandom_range(0, 2));
            4, 5:    e = 8'(117 + $urandom_range(0, 20));
            default: e = 8'($urandom);
        endcase
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    initial begin
        logic [15:0] a, b;
        int          t;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset outputs", 32'({dz_o, s_o, e_o, m_o}), 32'd0);
        nreset = 1'b1;
        @(negedge clk);
        check("ready_o after reset", 32'(ready_o), 32'd1);
        check("valid_o after reset", 32'(valid_o), 32'd0);

        // Hand-computed values pinning the reference model
        check("model 1/1",   32'(model(16'h3F80, 16'h3F80)), 32'h03F80);
        check("model 3/2",   32'(model(16'h4040, 16'h4000)), 32'h03FC0);
        check("model 1/3",   32'(model(16'h3F80, 16'h4040)), 32'h03EAA);
        check("model -6/2",  32'(model(16'hC0C0, 16'h4000)), 32'h0C040);
        check("model ovf",   32'(model(16'h7F00, 16'h0080)), 32'h07F7F);
        check("model 2/1",   32'(model(16'h4000, 16'h3F80)), 32'h04000);

        // Directed values against the DUT
        do_op(16'h3F80, 16'h3F80, 18'h03F80); drain();
        do_op(16'h4040, 16'h4000, 18'h03FC0); drain();
        do_op(16'h3F80, 16'h4040, 18'h03EAA); drain();
        do_op(16'hC0C0, 16'h4000, 18'h0C040); drain();
        do_op(16'h7F00, 16'h0080, 18'h07F7F); drain();
        do_op(16'h0080, 16'h7F00, model(16'h0080, 16'h7F00)); drain();

        // Downstream stall: result must hold with ready_o low
        rdy_mode = 2;
        do_op(16'hC0C0, 16'h4000, 18'h0C040);
        t = 0;
        while (!valid_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("valid_o under stall", 32'(valid_o), 32'd1);
        repeat (5) @(negedge clk);
        check("valid_o held", 32'(valid_o), 32'd1);
        rdy_mode = 0;
        drain();

        // Second request while busy is ignored
        do_op(16'h4040, 16'h4000, 18'h03FC0);
        repeat (4) begin
            @(negedge clk);
            valid_i = 1'b1;
            {sa_i, ea_i, ma_i} = 16'h4200;
            {sb_i, eb_i, mb_i} = 16'h3F80;
            @(negedge clk);
            check("ready_o while busy", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        drain();
        repeat (15) @(negedge clk);

        // Reset in the middle of division aborts the operation
        do_op(16'h3F80, 16'h4040, 18'h03EAA);
        repeat (4) @(posedge clk);
        #1;
        nreset = 1'b0;
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(negedge clk);
        check("abort valid_o", 32'(valid_o), 32'd0);
        check("abort outputs", 32'({dz_o, s_o, e_o, m_o}), 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        check("abort ready_o", 32'(ready_o), 32'd1);
        repeat (14) @(negedge clk);
        check("no result after abort", 32'(valid_o), 32'd0);
        do_op(16'h4000, 16'h3F80, 18'h04000); drain();

`ifdef BF16_DIV_SPECIAL_EN
        check("model 1/0",   32'(model(16'h3F80, 16'h0000)), 32'h37F80);
        check("model inf/1", 32'(model(16'h7F80, 16'h3F80)), 32'h27FC0);
        do_op(16'h3F80, 16'h0000, 18'h37F80); drain();
        do_op(16'h7F80, 16'h3F80, 18'h27FC0); drain();
        do_op(16'h0000, 16'h0000, 18'h27FC0); drain();
        do_op(16'h8000, 16'h4000, 18'h28000); drain();
`endif

        // Randomized operands with random downstream back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 120; i++) begin
            a = rand_op();
            b = rand_op();
            do_op(a, b, model(a, b));
        end
        drain();
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
